mem_stage: RTL and testbench
============================

MEM_STAGE -- requirements
Module: mem_stage

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset, with ports named clk and rst.
REQ-002 The block SHALL have the ports listed below (name  direction  width  meaning):
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- ValidIn  in  1  execute-stage instruction valid
- AluRes  in  16  ALU result / memory address
- RtOut  in  16  store data
- RegWriteIn, DMemWriteIn, DMemEnIn, MemToRegIn, DMemDumpIn  in  1 each  control bits from execute
- RdAddrIn  in  3  destination register
- MemDone  in  1  memory access complete (ack)
- MemRdData  in  16  load data, valid when MemDone=1
- MemReq  out  1  memory request
- MemWr  out  1  1=store, 0=load
- MemAddr  out  16  access address
- MemDataOut  out  16  store data
- Stall  out  1  upstream must hold inputs
- WbValid  out  1  writeback record valid (one-cycle pulse per instruction)
- WbRegWrite  out  1  write register file
- WbRdAddr  out  3  writeback register
- WbData  out  16  writeback data
- Halt  out  1  sticky; dump instruction retired
- MemErr  out  1  sticky; memory timeout

Function
REQ-003 The FSM SHALL have states IDLE, ACCESS and HALT.
REQ-004 Accept SHALL be ValidIn & ~Stall, where Stall = (state != IDLE).
REQ-005 A memory op SHALL be defined as DMemEnIn=1; DMemWriteIn with DMemEnIn=0 SHALL be treated as a non-memory op with no store.
REQ-006 On accept of a non-memory op with DMemDumpIn=0, the next edge SHALL load the Wb* registers: WbValid=1, WbData=AluRes, WbRdAddr=RdAddrIn, WbRegWrite=RegWriteIn; latency is 1 cycle and the state stays IDLE.
REQ-007 On accept of a memory op, the next edge SHALL latch AluRes, RtOut, DMemWriteIn, MemToRegIn, RegWriteIn and RdAddrIn, go to ACCESS, and clear the timeout counter.
REQ-008 In ACCESS, the block SHALL drive MemReq=1, MemAddr=latched address, MemWr=latched DMemWrite and MemDataOut=latched store data, all constant until exit.
REQ-009 In ACCESS with MemDone=1, the next edge SHALL return to IDLE and load the Wb* registers: WbValid=1, WbRdAddr=latched Rd, WbRegWrite=latched RegWrite & ~latched DMemWrite, WbData=(latched MemToReg ? MemRdData : latched AluRes).
REQ-010 MemDone SHALL be ignored outside ACCESS.
REQ-011 No accept SHALL occur during the MemDone cycle, because Stall=1 for all of ACCESS; minimum memory-op occupancy is 2 cycles (accept to next accept = 2 + wait).
REQ-012 A 4-bit timeout counter SHALL increment on each ACCESS cycle with MemDone=0.
REQ-013 When the counter reaches 15 with MemDone=0, the next edge SHALL go to HALT with MemErr=1 and Halt=1, drop MemReq, and set WbValid=0.
REQ-014 On accept with DMemDumpIn=1 (with DMemEnIn ignored), the next edge SHALL go to HALT with Halt=1 and WbValid=0.
REQ-015 HALT SHALL be terminal until rst: Stall=1, MemReq=0, WbValid=0.
REQ-016 In every cycle where no Wb load occurs, WbValid SHALL be 0; WbData, WbRdAddr and WbRegWrite SHALL hold their last values.
REQ-017 Outside ACCESS, MemReq and MemWr SHALL be 0; MemAddr and MemDataOut SHALL be don't-care but driven to 0.

Reset
REQ-018 With rst=1 at an edge, the block SHALL set state=IDLE, clear the counter and latched registers, and drive every output to 0 (Stall=0).
REQ-019 rst SHALL take priority over every event, including MemDone, timeout and dump in the same cycle.
REQ-020 A reset during ACCESS SHALL drop MemReq the cycle after the reset edge, and the pending access SHALL produce no WbValid.

Verification
REQ-021 ALU op: ValidIn=1, DMemEnIn=0, AluRes=0x1234, RdAddrIn=5, RegWriteIn=1 -> next cycle WbValid=1, WbData=0x1234, WbRdAddr=5, WbRegWrite=1, Stall=0 throughout.
REQ-022 Load with 3-cycle memory: AluRes=0x0040, MemToReg=1, MemDone on the 3rd ACCESS cycle with MemRdData=0xBEEF -> MemReq=1 for 3 cycles, MemAddr=0x0040, MemWr=0, Stall=1 for 3 cycles, then WbValid=1 with WbData=0xBEEF.
REQ-023 Store: DMemWriteIn=1, AluRes=0x0010, RtOut=0xA5A5, RegWriteIn=1, MemDone after 1 cycle -> MemWr=1, MemDataOut=0xA5A5, then WbValid=1 with WbRegWrite=0.
REQ-024 Back-to-back ALU ops on consecutive cycles -> WbValid high two cycles in a row with matching data; ALU op presented during ACCESS is held (Stall=1) and retires 1 cycle after the access completes.
REQ-025 Timeout: MemDone held at 0 -> after 15 ACCESS cycles MemErr=1, Halt=1, MemReq=0; subsequent ValidIn is ignored; rst clears everything.
REQ-026 Dump: accept with DMemDumpIn=1 -> Halt=1 and Stall=1 from the next cycle, WbValid=0; reset asserted mid-load -> MemReq=0 the next cycle and no WbValid.

Source files
------------

// File: rtl/mem_stage.sv
// ============================================================================
// Module   : mem_stage
// Brief    : Pipeline memory stage with handshaked data-memory access, a
//            15-cycle access timeout and a terminal halt state.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_stage (
  input  logic        clk,
  input  logic        rst,
  input  logic        ValidIn,
  input  logic [15:0] AluRes,
  input  logic [15:0] RtOut,
  input  logic        RegWriteIn,
  input  logic        DMemWriteIn,
  input  logic        DMemEnIn,
  input  logic        MemToRegIn,
  input  logic        DMemDumpIn,
  input  logic [2:0]  RdAddrIn,
  input  logic        MemDone,
  input  logic [15:0] MemRdData,
  output logic        MemReq,
  output logic        MemWr,
  output logic [15:0] MemAddr,
  output logic [15:0] MemDataOut,
  output logic        Stall,
  output logic        WbValid,
  output logic        WbRegWrite,
  output logic [2:0]  WbRdAddr,
  output logic [15:0] WbData,
  output logic        Halt,
  output logic        MemErr
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    HALT   = 2'd2
  } state_t;

  // Counter value whose increment completes the fifteenth unacknowledged cycle.
  localparam logic [3:0] c_TO_LAST = 4'd14;

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [15:0] addr_q, addr_d;
  logic [15:0] wdata_q, wdata_d;
  logic        wr_q, wr_d;
  logic        m2r_q, m2r_d;
  logic        rw_q, rw_d;
  logic [2:0]  rd_q, rd_d;
  logic        wb_valid_q, wb_valid_d;
  logic        wb_rw_q, wb_rw_d;
  logic [2:0]  wb_rd_q, wb_rd_d;
  logic [15:0] wb_data_q, wb_data_d;
  logic        halt_q, halt_d;
  logic        err_q, err_d;

  logic w_access;
  logic w_accept;

  assign w_access = (state_q == ACCESS);
  assign w_accept = ValidIn && (state_q == IDLE);

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    wr_d       = wr_q;
    m2r_d      = m2r_q;
    rw_d       = rw_q;
    rd_d       = rd_q;
    wb_valid_d = 1'b0;
    wb_rw_d    = wb_rw_q;
    wb_rd_d    = wb_rd_q;
    wb_data_d  = wb_data_q;
    halt_d     = halt_q;
    err_d      = err_q;

    case (state_q)
      IDLE: begin
        if (w_accept) begin
          if (DMemDumpIn) begin
            state_d = HALT;
            halt_d  = 1'b1;
          end else if (DMemEnIn) begin
            state_d = ACCESS;
            cnt_d   = 4'd0;
            addr_d  = AluRes;
            wdata_d = RtOut;
            wr_d    = DMemWriteIn;
            m2r_d   = MemToRegIn;
            rw_d    = RegWriteIn;
            rd_d    = RdAddrIn;
          end else begin
            wb_valid_d = 1'b1;
            wb_data_d  = AluRes;
            wb_rd_d    = RdAddrIn;
            wb_rw_d    = RegWriteIn;
          end
        end
      end
      ACCESS: begin
        if (MemDone) begin
          state_d    = IDLE;
          wb_valid_d = 1'b1;
          wb_rd_d    = rd_q;
          wb_rw_d    = rw_q && !wr_q;
          wb_data_d  = m2r_q ? MemRdData : addr_q;
        end else begin
          cnt_d = cnt_q + 4'd1;
          if (cnt_q == c_TO_LAST) begin
            state_d = HALT;
            halt_d  = 1'b1;
            err_d   = 1'b1;
          end
        end
      end
      HALT:    state_d = HALT;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      cnt_q      <= 4'd0;
      addr_q     <= 16'd0;
      wdata_q    <= 16'd0;
      wr_q       <= 1'b0;
      m2r_q      <= 1'b0;
      rw_q       <= 1'b0;
      rd_q       <= 3'd0;
      wb_valid_q <= 1'b0;
      wb_rw_q    <= 1'b0;
      wb_rd_q    <= 3'd0;
      wb_data_q  <= 16'd0;
      halt_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      wr_q       <= wr_d;
      m2r_q      <= m2r_d;
      rw_q       <= rw_d;
      rd_q       <= rd_d;
      wb_valid_q <= wb_valid_d;
      wb_rw_q    <= wb_rw_d;
      wb_rd_q    <= wb_rd_d;
      wb_data_q  <= wb_data_d;
      halt_q     <= halt_d;
      err_q      <= err_d;
    end
  end

  assign MemReq     = w_access;
  assign MemWr      = w_access && wr_q;
  assign MemAddr    = w_access ? addr_q  : 16'd0;
  assign MemDataOut = w_access ? wdata_q : 16'd0;
  assign Stall      = (state_q != IDLE);
  assign WbValid    = wb_valid_q;
  assign WbRegWrite = wb_rw_q;
  assign WbRdAddr   = wb_rd_q;
  assign WbData     = wb_data_q;
  assign Halt       = halt_q;
  assign MemErr     = err_q;

endmodule

`default_nettype wire

// File: tb/tb_mem_stage.sv
// ============================================================================
// Module   : tb_mem_stage
// Brief    : Self-checking bench for mem_stage: vector table, random ops
//            against a transaction-level model, and hand-written corner cases.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mem_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        ValidIn, RegWriteIn, DMemWriteIn, DMemEnIn, MemToRegIn, DMemDumpIn;
  logic [15:0] AluRes, RtOut, MemRdData;
  logic [2:0]  RdAddrIn;
  logic        MemDone;
  logic        MemReq, MemWr, Stall, WbValid, WbRegWrite, Halt, MemErr;
  logic [15:0] MemAddr, MemDataOut, WbData;
  logic [2:0]  WbRdAddr;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  mem_stage dut (
    .clk(clk), .rst(rst), .ValidIn(ValidIn), .AluRes(AluRes), .RtOut(RtOut),
    .RegWriteIn(RegWriteIn), .DMemWriteIn(DMemWriteIn), .DMemEnIn(DMemEnIn),
    .MemToRegIn(MemToRegIn), .DMemDumpIn(DMemDumpIn), .RdAddrIn(RdAddrIn),
    .MemDone(MemDone), .MemRdData(MemRdData), .MemReq(MemReq), .MemWr(MemWr),
    .MemAddr(MemAddr), .MemDataOut(MemDataOut), .Stall(Stall), .WbValid(WbValid),
    .WbRegWrite(WbRegWrite), .WbRdAddr(WbRdAddr), .WbData(WbData), .Halt(Halt),
    .MemErr(MemErr)
  );

  typedef struct {
    logic        en, wr, m2r, rw;
    logic [2:0]  rd;
    logic [15:0] alu, rt;
    int          lat;
    logic [15:0] rdata;
    logic [15:0] exp_data;
    logic        exp_rw;
  } vec_t;

  vec_t tbl[6];

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%h want=%h", nm, act, exp);
    end
  endtask

  task automatic idle_inputs();
    ValidIn = 0; RegWriteIn = 0; DMemWriteIn = 0; DMemEnIn = 0; MemToRegIn = 0;
    DMemDumpIn = 0; AluRes = 0; RtOut = 0; RdAddrIn = 0; MemDone = 0; MemRdData = 0;
  endtask

  task automatic do_reset();
    rst = 1;
    @(posedge clk); #1;
    rst = 0;
  endtask

  // One instruction from presentation to writeback, checking every cycle.
  task automatic run_op(input vec_t v);
    @(negedge clk);
    chk("stall_before", {15'd0, Stall}, 16'd0);
    ValidIn = 1; DMemEnIn = v.en; DMemWriteIn = v.wr; MemToRegIn = v.m2r;
    RegWriteIn = v.rw; RdAddrIn = v.rd; AluRes = v.alu; RtOut = v.rt; DMemDumpIn = 0;
    @(posedge clk); #1;
    ValidIn = 0; AluRes = $urandom; RtOut = $urandom;
    if (v.en) begin
      for (int k = 1; k <= v.lat; k++) begin
        chk("memreq", {15'd0, MemReq}, 16'd1);
        chk("memaddr", MemAddr, v.alu);
        chk("memwr", {15'd0, MemWr}, {15'd0, v.wr});
        chk("memdout", MemDataOut, v.rt);
        chk("stall_acc", {15'd0, Stall}, 16'd1);
        chk("wbv_acc", {15'd0, WbValid}, 16'd0);
        MemDone = (k == v.lat);
        MemRdData = (k == v.lat) ? v.rdata : 16'($urandom);
        @(posedge clk); #1;
      end
      MemDone = 0;
    end
    chk("wbvalid", {15'd0, WbValid}, 16'd1);
    chk("wbdata", WbData, v.exp_data);
    chk("wbrd", {13'd0, WbRdAddr}, {13'd0, v.rd});
    chk("wbrw", {15'd0, WbRegWrite}, {15'd0, v.exp_rw});
    chk("memreq_done", {15'd0, MemReq}, 16'd0);
    chk("stall_done", {15'd0, Stall}, 16'd0);
  endtask

  // Writeback outcome derived from the instruction's meaning, not the datapath.
  function automatic vec_t model(input vec_t v);
    vec_t r = v;
    if (v.en && v.m2r) r.exp_data = v.rdata;
    else               r.exp_data = v.alu;
    r.exp_rw = v.en ? (v.rw && !v.wr) : v.rw;
    return r;
  endfunction

  initial begin
    int n;
    vec_t rv;
    tbl[0] = '{1'b0, 1'b0, 1'b0, 1'b1, 3'd5, 16'h1234, 16'h0000, 0,  16'h0000, 16'h1234, 1'b1};
    tbl[1] = '{1'b0, 1'b1, 1'b1, 1'b1, 3'd7, 16'hFFFF, 16'h1111, 0,  16'h0000, 16'hFFFF, 1'b1};
    tbl[2] = '{1'b1, 1'b0, 1'b1, 1'b1, 3'd2, 16'h0040, 16'h0000, 3,  16'hBEEF, 16'hBEEF, 1'b1};
    tbl[3] = '{1'b1, 1'b1, 1'b0, 1'b1, 3'd1, 16'h0010, 16'hA5A5, 1,  16'h0000, 16'h0010, 1'b0};
    tbl[4] = '{1'b1, 1'b0, 1'b1, 1'b1, 3'd4, 16'h0ABC, 16'h0000, 15, 16'h5A5A, 16'h5A5A, 1'b1};
    tbl[5] = '{1'b1, 1'b0, 1'b0, 1'b1, 3'd3, 16'h3333, 16'h0000, 2,  16'h9999, 16'h3333, 1'b1};

    idle_inputs();
    do_reset();
    chk("rst_stall", {15'd0, Stall}, 16'd0);
    chk("rst_memreq", {15'd0, MemReq}, 16'd0);
    chk("rst_wbv", {15'd0, WbValid}, 16'd0);
    chk("rst_wbdata", WbData, 16'd0);
    chk("rst_halt", {14'd0, Halt, MemErr}, 16'd0);
    chk("rst_memaddr", MemAddr, 16'd0);

    for (int i = 0; i < 6; i++) run_op(tbl[i]);

    for (int i = 0; i < 40; i++) begin
      rv.en = 1'($urandom); rv.wr = 1'($urandom); rv.m2r = 1'($urandom);
      rv.rw = 1'($urandom); rv.rd = 3'($urandom); rv.alu = 16'($urandom);
      rv.rt = 16'($urandom); rv.lat = int'($urandom_range(1, 15));
      rv.rdata = 16'($urandom); rv.exp_data = 0; rv.exp_rw = 0;
      run_op(model(rv));
    end

    // ALU op held behind a two-cycle load, retiring right after it.
    @(negedge clk);
    ValidIn = 1; DMemEnIn = 1; MemToRegIn = 1; RegWriteIn = 1; RdAddrIn = 3;
    AluRes = 16'h0200; DMemWriteIn = 0;
    @(posedge clk); #1;
    DMemEnIn = 0; MemToRegIn = 0; AluRes = 16'h7777; RdAddrIn = 6;
    chk("hold_stall", {15'd0, Stall}, 16'd1);
    @(posedge clk); #1;
    MemDone = 1; MemRdData = 16'h1111;
    @(posedge clk); #1;
    MemDone = 0;
    chk("hold_ld_wbv", {15'd0, WbValid}, 16'd1);
    chk("hold_ld_data", WbData, 16'h1111);
    @(posedge clk); #1;
    ValidIn = 0;
    chk("hold_alu_wbv", {15'd0, WbValid}, 16'd1);
    chk("hold_alu_data", WbData, 16'h7777);
    chk("hold_alu_rd", {13'd0, WbRdAddr}, 16'd6);

    // MemDone outside ACCESS must not produce anything.
    MemDone = 1;
    @(posedge clk); #1;
    MemDone = 0;
    chk("stray_done", {15'd0, WbValid}, 16'd0);

    // Timeout after fifteen unacknowledged access cycles.
    @(negedge clk);
    ValidIn = 1; DMemEnIn = 1; AluRes = 16'h0400;
    @(posedge clk); #1;
    ValidIn = 0;
    n = 0;
    while (MemReq && n < 20) begin
      n++;
      @(posedge clk); #1;
    end
    chk("to_cycles", 16'(n), 16'd15);
    chk("to_err", {15'd0, MemErr}, 16'd1);
    chk("to_halt", {15'd0, Halt}, 16'd1);
    chk("to_stall", {15'd0, Stall}, 16'd1);
    chk("to_wbv", {15'd0, WbValid}, 16'd0);
    ValidIn = 1; DMemEnIn = 0; AluRes = 16'h5555;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      chk("halt_ignore", {14'd0, WbValid, MemReq}, 16'd0);
    end
    ValidIn = 0;
    do_reset();
    chk("to_rst", {12'd0, Halt, MemErr, Stall, MemReq}, 16'd0);

    // Dump instruction, with DMemEnIn set to show it is ignored.
    @(negedge clk);
    ValidIn = 1; DMemDumpIn = 1; DMemEnIn = 1;
    @(posedge clk); #1;
    ValidIn = 0; DMemDumpIn = 0; DMemEnIn = 0;
    chk("dump_halt", {15'd0, Halt}, 16'd1);
    chk("dump_stall", {15'd0, Stall}, 16'd1);
    chk("dump_misc", {13'd0, WbValid, MemReq, MemErr}, 16'd0);
    do_reset();

    // Reset mid-load beats a same-cycle MemDone.
    @(negedge clk);
    ValidIn = 1; DMemEnIn = 1; MemToRegIn = 1; RegWriteIn = 1; AluRes = 16'h0800;
    @(posedge clk); #1;
    ValidIn = 0;
    chk("rl_memreq", {15'd0, MemReq}, 16'd1);
    rst = 1; MemDone = 1; MemRdData = 16'hDEAD;
    @(posedge clk); #1;
    rst = 0; MemDone = 0;
    chk("rl_memreq_drop", {15'd0, MemReq}, 16'd0);
    chk("rl_wbv", {15'd0, WbValid}, 16'd0);
    chk("rl_stall", {15'd0, Stall}, 16'd0);
    @(posedge clk); #1;
    chk("rl_wbv2", {15'd0, WbValid}, 16'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
